control_block_sequencer: RTL and testbench

Drives the opcode input of the control block from a small preloaded opcode program and collects each 16-bit result. It sits upstream of the control block: its `opcode` output feeds `ui_in[3:0]`, and its `res_in` input is the control block's `{uo_out, uio_out}`. Each result goes to a downstream consumer over a valid/ready handshake, tagged with its program index.

---
 rtl/control_block_sequencer_if.sv | 27 ++
 rtl/control_block_sequencer.sv | 157 +++++++++++++++
 tb/tb_control_block_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_block_sequencer_if.sv
// Opcode-load and result handshake bundle between the sequencer and its host.
// master = sequencer side, slave = host / consumer side.
interface control_block_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          load_valid;
    logic [3:0]    load_op;
    logic          load_ready;
    logic [3:0]    opcode;
    logic [15:0]   res_in;
    logic          res_valid;
    logic [15:0]   res_data;
    logic [AW-1:0] res_idx;
    logic          res_ready;

    modport master (
        input  load_valid, load_op, res_in, res_ready,
        output load_ready, opcode, res_valid, res_data, res_idx
    );

    modport slave (
        output load_valid, load_op, res_in, res_ready,
        input  load_ready, opcode, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/control_block_sequencer.sv
// Replays a preloaded opcode program into the control block and hands each
// 16-bit result, tagged with its program index, to a downstream consumer.
module control_block_sequencer #(
    parameter int DEPTH          = 8,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     abort,
    control_block_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2:0]               o_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(RESULT_LATENCY + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready && ena
    // and abort is low; valid never depends combinationally on ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [3:0]      r_buf [DEPTH];
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_wait;
    logic            r_busy;
    logic            r_done;
    logic            r_res_valid;
    logic [3:0]      r_opcode;
    logic [15:0]     r_res_data;
    logic [AW-1:0]   r_res_idx;

    logic            w_load_ready;
    logic            w_load;
    logic [AW:0]     w_count_post;
    logic [3:0]      w_first_op;
    logic            w_last;
    logic [AW-1:0]   w_rd_next;

    // count never exceeds DEPTH (a power of two), so its MSB marks "full".
    assign w_load_ready = (r_state == S_IDLE) && !r_count[AW];
    assign w_load       = ena && !abort && bus.load_valid && w_load_ready;
    assign w_count_post = r_count + (AW+1)'(w_load);
    // A same-cycle load into slot 0 has not reached the array yet; forward it.
    assign w_first_op   = (w_load && (r_count == '0)) ? bus.load_op : r_buf[0];
    assign w_last       = ({1'b0, r_rd_ptr} == (r_count - (AW+1)'(1)));
    assign w_rd_next    = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf[r_count[AW-1:0]] <= bus.load_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_opcode    <= 4'd0;
            r_res_data  <= 16'd0;
            r_res_idx   <= '0;
        end else if (ena) begin
            if (abort) begin
                r_state     <= S_IDLE;
                r_count     <= '0;
                r_rd_ptr    <= '0;
                r_wait      <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_res_valid <= 1'b0;
                r_opcode    <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_done  <= 1'b0;
                        r_count <= w_count_post;
                        if (start) begin
                            r_busy <= 1'b1;
                            if (w_count_post == '0) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_opcode <= 4'd0;
                            end else begin
                                r_state  <= S_ISSUE;
                                r_rd_ptr <= '0;
                                r_opcode <= w_first_op;
                            end
                        end
                    end
                    S_ISSUE: begin
                        r_wait  <= LW'(RESULT_LATENCY);
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_wait == LW'(1)) begin
                            r_res_data  <= bus.res_in;
                            r_res_idx   <= r_rd_ptr;
                            r_res_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_wait <= r_wait - LW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (bus.res_ready) begin
                            r_res_valid <= 1'b0;
                            if (w_last) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_opcode <= 4'd0;
                            end else begin
                                r_state  <= S_ISSUE;
                                r_rd_ptr <= w_rd_next;
                                r_opcode <= r_buf[w_rd_next];
                            end
                        end
                    end
                    S_DONE: begin
                        r_done   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.opcode     = r_opcode;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_idx    = r_res_idx;
    assign busy           = r_busy;
    assign done           = r_done;
    assign count          = r_count;
    assign o_state        = r_state;
endmodule

// File: tb/tb_control_block_sequencer.sv
// Directed bench for control_block_sequencer with a combinational control-block stand-in.
module tb_control_block_sequencer;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;
  localparam int AW    = 3;
  localparam int GAP   = LAT + 2;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena, start, abort;
  logic          busy, done;
  logic [AW:0]   count;
  logic [2:0]    dbg_state;

  control_block_sequencer_if #(.DEPTH(DEPTH)) bus ();

  // Control block stand-in: result = opcode + 0x100
  assign bus.res_in = {12'h000, bus.opcode} + 16'h0100;

  control_block_sequencer #(.DEPTH(DEPTH), .RESULT_LATENCY(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [AW+15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [3:0] op);
    bus.load_valid = 1'b1;
    bus.load_op    = op;
    step();
    bus.load_valid = 1'b0;
  endtask

  // Starts the program and consumes results against exp_q; gap>0 checks handshake spacing.
  task automatic run_program(input int n_ops, input int gap);
    int cyc;
    int hs;
    int last_hs;
    bit seen_done;
    hs = 0;
    last_hs = 0;
    seen_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 200 && !seen_done) begin
      if (bus.res_valid) begin
        if (exp_q.size() > 0) begin
          chk("res_idx_data", {bus.res_idx, bus.res_data}, exp_q[0]);
        end else begin
          chk("unexpected_res", 1, 0);
        end
        if (bus.res_ready) begin
          if (gap > 0) chk("res_spacing", cyc, 2 + LAT + hs * gap);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs++;
          last_hs = cyc;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_after_last", cyc, last_hs + 1);
        chk("done_res_valid", bus.res_valid, 0);
        chk("done_opcode", bus.opcode, 0);
        chk("result_count", hs, n_ops);
      end
      step();
      cyc++;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("post_done_busy", busy, 0);
    chk("post_done_done", done, 0);
    chk("post_done_count", count, 0);
    chk("post_done_state", dbg_state, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ena = 1'b1; start = 1'b0; abort = 1'b0;
    bus.load_valid = 1'b0; bus.load_op = 4'd0; bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_idx", bus.res_idx, 0);
    chk("rst_state", dbg_state, 0);
    #2 rst_n = 1'b1;
    step();
    chk("idle_load_ready", bus.load_ready, 1);

    // Load and run 3
    load_one(4'd3); load_one(4'd5); load_one(4'd9);
    chk("t1_count", count, 3);
    exp_q.push_back({3'd0, 16'h0103});
    exp_q.push_back({3'd1, 16'h0105});
    exp_q.push_back({3'd2, 16'h0109});
    run_program(3, GAP);

    // Full buffer: ninth load refused
    for (int i = 0; i < 9; i++) begin
      chk("full_load_ready", bus.load_ready, (i < 8) ? 1 : 0);
      load_one(4'(i + 1));
    end
    chk("full_count", count, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'h0101 + 16'(i)});
    run_program(8, GAP);

    // Backpressure: 5 cycles of res_ready low in HOLD
    load_one(4'd7);
    bus.res_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("bp_issue_opcode", bus.opcode, 7);
    chk("bp_busy", busy, 1);
    chk("bp_load_ready_busy", bus.load_ready, 0);
    step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_data", bus.res_data, 16'h0107);
      chk("bp_res_idx", bus.res_idx, 0);
      chk("bp_opcode", bus.opcode, 7);
      if (k < 4) step();
    end
    bus.res_ready = 1'b1;
    step();
    chk("bp_done", done, 1);
    chk("bp_res_valid_after", bus.res_valid, 0);
    step();
    chk("bp_busy_after", busy, 0);

    // Empty start
    chk("empty_count", count, 0);
    run_program(0, 0);

    // Abort during WAIT of entry 1
    load_one(4'd2); load_one(4'd4);
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    chk("ab_state_wait", dbg_state, 2);
    chk("ab_opcode_e1", bus.opcode, 4);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("ab_state", dbg_state, 0);
    chk("ab_opcode", bus.opcode, 0);
    chk("ab_busy", busy, 0);
    chk("ab_count", count, 0);
    chk("ab_res_valid", bus.res_valid, 0);
    for (int k = 0; k < 4; k++) begin
      chk("ab_no_done", done, 0);
      step();
    end

    // ena low for 3 cycles in WAIT
    load_one(4'd6);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("ena_state_wait", dbg_state, 2);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ena_frozen_state", dbg_state, 2);
      chk("ena_frozen_valid", bus.res_valid, 0);
    end
    ena = 1'b1;
    step();
    chk("ena_cyc6_valid", bus.res_valid, 0);
    step();
    chk("ena_cyc7_valid", bus.res_valid, 1);
    chk("ena_cyc7_data", bus.res_data, 16'h0106);
    step();
    chk("ena_done", done, 1);
    step();
    chk("ena_busy_after", busy, 0);

    // Async reset mid-HOLD
    load_one(4'd8);
    bus.res_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("ar_hold_valid", bus.res_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_res_valid", bus.res_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_opcode", bus.opcode, 0);
    chk("ar_count", count, 0);
    chk("ar_res_data", bus.res_data, 0);
    chk("ar_state", dbg_state, 0);
    #2 rst_n = 1'b1;
    step();
    bus.res_ready = 1'b1;
    chk("ar_load_ready", bus.load_ready, 1);
    load_one(4'd5);
    chk("ar_count_after", count, 1);
    exp_q.push_back({3'd0, 16'h0105});
    run_program(1, GAP);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
